// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_bus_filter.sv
// SCL/SDA front end: 2-FF synchronizer, FILT_LEN stable-sample glitch filter,
// then edge / START / STOP detection on the filtered levels.
module i2c_bus_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int CW = $clog2(FILT_LEN + 1);

    // index 0 = SCL, index 1 = SDA
    logic [1:0]         sync1_q, sync2_q, filt_q, prev_q;
    logic [1:0][CW-1:0] cnt_q;

    // Synchronize, then change the filtered level only after FILT_LEN differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {sda_i, scl_i};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edges of filtered levels; START/STOP need SCL to have been high on both samples.
    always_comb begin
        scl_f     = filt_q[0];
        sda_f     = filt_q[1];
        scl_rise  =  filt_q[0] & ~prev_q[0];
        scl_fall  = ~filt_q[0] &  prev_q[0];
        start_det =  prev_q[1] & ~filt_q[1] & filt_q[0] & prev_q[0];
        stop_det  = ~prev_q[1] &  filt_q[1] & filt_q[0] & prev_q[0];
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an N_REGS x 8-bit register file, auto-incrementing pointer
// and per-byte write strobes for local logic.
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         N_REGS     = 4,
    parameter int         FILT_LEN   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_oe,
    output logic [8*N_REGS-1:0]         regs_o,
    output logic                        wr_stb,
    output logic [$clog2(N_REGS)-1:0]   wr_addr,
    output logic                        busy
);
    import i2c_pkg::*;

    localparam int PW = $clog2(N_REGS);

    // SCL level itself is not needed here; its edges carry everything.
    logic scl_f_unused;
    logic sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_f     (scl_f_unused),
        .sda_f     (sda_f),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e                 state_q, state_d;
    logic [3:0]                 bitcnt_q, bitcnt_d;
    logic [7:0]                 shift_q, shift_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic [N_REGS-1:0][7:0]     regs_q, regs_d;
    logic                       sda_oe_q, sda_oe_d;
    logic                       busy_q, busy_d;
    logic                       first_q, first_d;   // next written byte is the pointer
    logic                       phase_q, phase_d;   // ACK slot: drive done / host ACK seen
    logic                       wr_pend_q, wr_pend_d;
    logic                       wr_stb_q, wr_stb_d;
    logic [PW-1:0]              wr_addr_q, wr_addr_d;

    logic [7:0] byte_in;
    assign byte_in = {shift_q[6:0], sda_f};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            regs_q    <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            first_q   <= 1'b0;
            phase_q   <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            regs_q    <= regs_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            first_q   <= first_d;
            phase_q   <= phase_d;
            wr_pend_q <= wr_pend_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Next state: START/STOP override everything, otherwise advance on SCL edges.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && bitcnt_q == 4'd7)
                              state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK: if (scl_fall && phase_q)
                              state_d = (shift_q[0] == I2C_RW_READ) ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (scl_rise && bitcnt_q == 4'd7) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && phase_q) state_d = WR_BYTE;
                RD_BYTE:  if (scl_fall && bitcnt_q == 4'd8) state_d = RD_ACK;
                RD_ACK:   if (scl_rise && sda_f == I2C_NACK) state_d = WAIT_STOP;
                          else if (scl_fall && phase_q) state_d = RD_BYTE;
                default:  ;
            endcase
        end
    end

    // Datapath next values: shifter, pointer, register commit, SDA drive, busy.
    always_comb begin
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        first_d   = first_q;
        phase_d   = phase_q;
        wr_pend_d = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;

        // A complete written byte lands one cycle after its 8th SCL rise.
        if (wr_pend_q) begin
            if (first_q) begin
                ptr_d   = shift_q[PW-1:0];
                first_d = 1'b0;
            end else begin
                regs_d[ptr_q] = shift_q;
                wr_stb_d      = 1'b1;
                wr_addr_d     = ptr_q;
                ptr_d         = ptr_q + 1'b1;
            end
        end

        if (start_det) begin
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd7) begin
                        phase_d = 1'b0;
                        busy_d  = (byte_in[7:1] == SLAVE_ADDR);
                    end
                end
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        if (state_q == ADDR_ACK) begin
                            if (shift_q[0] == I2C_RW_READ) begin
                                shift_d  = regs_q[ptr_q];
                                sda_oe_d = ~regs_q[ptr_q][7];
                                bitcnt_d = 4'd1;
                            end else begin
                                first_d = 1'b1;
                            end
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shift_d  = byte_in;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd7) begin
                        wr_pend_d = 1'b1;
                        phase_d   = 1'b0;
                    end
                end
                // bitcnt counts bits already placed on SDA; MSB went out on entry.
                RD_BYTE: if (scl_fall) begin
                    if (bitcnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                        if (sda_f == I2C_NACK) busy_d = 1'b0;
                        else                   phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        shift_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                        bitcnt_d = 4'd1;
                        phase_d  = 1'b0;
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        sda_oe  = sda_oe_q;
        regs_o  = regs_q;
        wr_stb  = wr_stb_q;
        wr_addr = wr_addr_q;
        busy    = busy_q;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (slave) endpoint with a small byte register file. It is the far end of the bus driven by the team's I2C master core. It is used as the on-chip loopback target in system benches and as a simple config-register target on boards. It watches SCL/SDA, matches a fixed 7-bit address, and ACKs writes and reads. It exposes the register file and per-byte write strobes to local logic.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address answered.
N_REGS, 4, number of 8-bit registers; power of 2, 2..16.
FILT_LEN, 3, consecutive identical synchronized samples needed before a filtered SCL/SDA level changes.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
scl_i  in  1  SCL pin level (async).
sda_i  in  1  SDA pin level (async).
sda_oe  out  1  1 = pull SDA low (open-drain); pad ties output to 0.
regs_o  out  8*N_REGS  register file, reg k at bits [8k+7:8k].
wr_stb  out  1  one-cycle pulse when a data byte is written to a register.
wr_addr  out  log2(N_REGS)  register index written (valid with wr_stb).
busy  out  1  high from an address-matched START until STOP, NACK exit or mismatch.

Behaviour:
- Reset, applied on a clk edge with rst=1: sda_oe=0, regs_o=0, wr_stb=0, wr_addr=0, busy=0, pointer=0, state=IDLE, filters preset to 1. Reset mid-transfer releases SDA in the same cycle and resumes only at the next START.
- Input path: 2-FF synchronizer, then FILT_LEN stable-sample filter, then edge detect on filtered SCL/SDA. Event latency is 2+FILT_LEN clk after the pin change. Pulses shorter than FILT_LEN clk are ignored.
- START: filtered SDA falls while filtered SCL=1. It is valid in every state, including a repeated START, and always goes to ADDR with the bit counter cleared.
- STOP: filtered SDA rises while filtered SCL=1. From any state it goes to IDLE, sets sda_oe=0 and busy=0.
- Data bits are sampled on SCL rising edges. SDA is only changed by the target on SCL falling edges.
- ADDR: shift 8 bits MSB first.
  - byte[7:1]==SLAVE_ADDR: go to ADDR_ACK and set busy=1.
  - Mismatch: go to IDLE with no ACK.
- ADDR_ACK: on the SCL fall after bit 8, set sda_oe=1. On the next SCL fall, set sda_oe=0.
  - R/W=0: go to WR_BYTE and set first_byte=1.
  - R/W=1: load regs[pointer] into the shifter and go to RD_BYTE.
- WR_BYTE: shift 8 bits.
  - first_byte=1: the byte sets pointer=byte mod N_REGS; wr_stb is not raised.
  - Otherwise: regs[pointer]<=byte, pulse wr_stb with wr_addr=pointer, then pointer<=pointer+1 (wraps mod N_REGS).
  - Register update and wr_stb occur 1 clk after the 8th SCL rise is detected.
  - Go to WR_ACK; the target always ACKs data.
- WR_ACK: same SDA timing as ADDR_ACK, then return to WR_BYTE.
- RD_BYTE: drive the MSB immediately on entry, which is at the SCL fall ending the ACK. Drive the next bits on each SCL fall, with sda_oe = ~bit. On the SCL fall after bit 8, set sda_oe=0 and go to RD_ACK.
- RD_ACK: sample SDA on the SCL rise.
  - 0 (ACK): pointer++ (wraps), load regs[pointer] on the next SCL fall, go to RD_BYTE.
  - 1 (NACK): pointer++, go to WAIT_STOP with busy=0.
- WAIT_STOP: sda_oe=0; wait for STOP or START.
- The pointer persists across transactions, so a read without a pointer write continues from the last pointer.
- A STOP or START in the middle of a byte discards the partial byte; registers are unchanged.
- A local read of regs_o during a bus write sees the old value until the update cycle.
- The target never stretches SCL.

Decomposition:
- Shared package i2c_pkg:
  - state encoding (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP);
  - I2C_RW_READ=1;
  - ACK=0 and NACK=1 constants.
- One sub-module, i2c_bus_filter (param FILT_LEN):
  - synchronizes and filters scl/sda;
  - outputs scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det.
  - The master core reuses it.

Test Plan:
- Write burst: START, 0xA0, 0x01, 0xAA, 0xBB, STOP -> ACK on all 4 bytes; regs[1]=0xAA, regs[2]=0xBB; two wr_stb pulses with wr_addr 1 then 2; busy low after STOP.
- Combined read: START 0xA0 0x02, repeated START 0xA1, read 2 bytes (ACK, NACK), STOP, after preload regs = {0x44,0x33,0x22,0x11} (reg3..reg0) -> master receives 0x33 then 0x44; final pointer=0.
- Wrap: pointer write 0x03 followed by data 0x5A, 0x6B -> regs[3]=0x5A, regs[0]=0x6B.
- Address mismatch: START 0xA2 0x01 0xFF STOP -> sda_oe never asserted, busy never high, regs unchanged, no wr_stb.
- Glitch and abort: a FILT_LEN-1 clk low pulse on SDA while SCL is high -> no START detected. A STOP after 4 data bits -> register unchanged and state IDLE.
- Reset mid-read: assert rst while sda_oe=1 -> sda_oe=0 on that edge and regs_o=0. The next transaction after a fresh START works normally.
